// File: rtl/mul_sequencer.sv
// Sequential shift-and-add multiplier with write-back handshake and Decode hazard stall.
// Optional MUL_EARLY_EXIT_EN: leave BUSY as soon as the remaining multiplier bits are all zero.
module mul_sequencer #(
  parameter int WIDTH        = 16,
  parameter int ADDRESSWIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    startE,
  input  logic                    cancel,
  input  logic [WIDTH-1:0]        operandAE,
  input  logic [WIDTH-1:0]        operandBE,
  input  logic [ADDRESSWIDTH-1:0] writeAddressE,
  input  logic [ADDRESSWIDTH-1:0] reg1ReadAddressD,
  input  logic [ADDRESSWIDTH-1:0] reg2ReadAddressD,
  input  logic                    wbGrant,
  output logic                    busy,
  output logic                    mulStallD,
  output logic                    wbRequest,
  output logic                    writeEnableMul,
  output logic [WIDTH-1:0]        resultMul,
  output logic [ADDRESSWIDTH-1:0] writeAddressMul
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, WRITE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]  mplier;
  logic [WIDTH-1:0]  acc;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  acc_next;
  logic [WIDTH-1:0]  mplier_next;
  logic              last_cycle;

  // Accumulator is WIDTH bits wide, so carries out of the top bit are dropped.
  always_comb begin
    acc_next    = acc + (mplier[0] ? mcand : '0);
    mplier_next = mplier >> 1;
    last_cycle  = (cnt == CW'(WIDTH - 1));
`ifdef MUL_EARLY_EXIT_EN
    if (mplier_next == '0) last_cycle = 1'b1;
`else
    last_cycle = last_cycle;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      mcand           <= '0;
      mplier          <= '0;
      acc             <= '0;
      cnt             <= '0;
      resultMul       <= '0;
      writeAddressMul <= '0;
    end else if (cancel) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (startE) begin
            mcand           <= operandAE;
            mplier          <= operandBE;
            writeAddressMul <= writeAddressE;
            acc             <= '0;
            cnt             <= '0;
            state           <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          cnt    <= cnt + CW'(1);
          if (last_cycle) begin
            resultMul <= acc_next;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (wbGrant) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy           = (state != IDLE);
  assign wbRequest      = (state == WRITE);
  assign writeEnableMul = (state == WRITE) && wbGrant && !cancel;

  // Stall on a pending destination, on a second issue while busy, or on the issuing op's own destination.
  assign mulStallD =
      (busy && ((reg1ReadAddressD == writeAddressMul) || (reg2ReadAddressD == writeAddressMul))) ||
      (busy && startE) ||
      (!busy && startE && !cancel &&
       ((reg1ReadAddressD == writeAddressE) || (reg2ReadAddressD == writeAddressE)));

endmodule
